// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer scheduling blocks.
package cnn_pkg;

  localparam int unsigned OcWidthDefault = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLoadRel,
    StConvGo,
    StConvWait,
    StFinish
  } sched_state_e;

endpackage

// File: rtl/conv_channel_sched.sv
// Walks output channels 0..last_oc: four-phase kernel load, conv launch, wait, repeat.
module conv_channel_sched
  import cnn_pkg::*;
#(
  parameter int unsigned OC_W = OcWidthDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OC_W-1:0] last_oc,
  input  logic            abort,
  output logic            c_load,
  input  logic            c_load_done,
  output logic [OC_W-1:0] out_c,
  output logic            conv_start,
  input  logic            conv_done,
  output logic            busy,
  output logic            done,
  output logic            err
);

  sched_state_e    state_q;
  logic [OC_W-1:0] last_oc_q;
  logic [OC_W-1:0] out_c_q;
  logic            c_load_q;
  logic            conv_start_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic accept;
  logic err_set;

  assign accept  = (state_q == StIdle) && start;
  // Handshake inputs arriving where no transfer is outstanding are protocol errors.
  assign err_set = (conv_done && (state_q != StConvWait)) ||
                   (c_load_done && (state_q == StIdle));

  // Outputs are loaded alongside the state they belong to, so they leave flops directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_oc_q    <= '0;
      out_c_q      <= '0;
      c_load_q     <= 1'b0;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      conv_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= err_set | (err_q & ~accept);

      if ((state_q != StIdle) && abort) begin
        state_q  <= StIdle;
        c_load_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              last_oc_q <= last_oc;
              out_c_q   <= '0;
              state_q   <= StLoad;
              c_load_q  <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          StLoad: begin
            if (c_load_done) begin
              state_q  <= StLoadRel;
              c_load_q <= 1'b0;
            end
          end
          StLoadRel: begin
            // Wait for the loader to drop its ack before launching the engine.
            if (!c_load_done) begin
              state_q      <= StConvGo;
              conv_start_q <= 1'b1;
            end
          end
          StConvGo: begin
            state_q <= StConvWait;
          end
          StConvWait: begin
            if (conv_done) begin
              if (out_c_q == last_oc_q) begin
                state_q <= StFinish;
                done_q  <= 1'b1;
              end else begin
                out_c_q  <= out_c_q + OC_W'(1);
                state_q  <= StLoad;
                c_load_q <= 1'b1;
              end
            end
          end
          StFinish: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q  <= StIdle;
            c_load_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign c_load     = c_load_q;
  assign out_c      = out_c_q;
  assign conv_start = conv_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_conv_channel_sched.sv
// Directed bench for conv_channel_sched; conv_start pulses are scored against a queue of channels.
module tb_conv_channel_sched;

  localparam int OC_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [OC_W-1:0] last_oc = '0;
  logic            abort = 1'b0;
  logic            c_load;
  logic            c_load_done = 1'b0;
  logic [OC_W-1:0] out_c;
  logic            conv_start;
  logic            conv_done = 1'b0;
  logic            busy;
  logic            done;
  logic            err;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int cs_cnt = 0;
  int rises = 0;
  logic cload_prev = 1'b0;
  logic [OC_W-1:0] exp_q[$];
  int d0, c0, r0;

  conv_channel_sched #(.OC_W(OC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .last_oc    (last_oc),
    .abort      (abort),
    .c_load     (c_load),
    .c_load_done(c_load_done),
    .out_c      (out_c),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock; sample #1 after the edge and score any conv_start pulse.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (c_load === 1'b1 && cload_prev !== 1'b1) rises++;
    cload_prev = c_load;
    if (done === 1'b1) done_cnt++;
    if (conv_start === 1'b1) begin
      cs_cnt++;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_underflow: observed conv_start with out_c %0h expected none", out_c);
      end
      if (exp_q.size() != 0) chk("sb_out_c", 32'(out_c), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic start_layer(input int last);
    last_oc = OC_W'(last);
    start = 1'b1;
    for (int i = 0; i <= last; i++) exp_q.push_back(OC_W'(i));
    cyc();
    start = 1'b0;
    last_oc = '0;
  endtask

  // Entered with c_load just raised for channel ch.
  task automatic do_channel(input int ch, input bit is_last, input int ack_dly,
                            input int hold, input int conv_dly);
    chk("c_load_hi", 32'(c_load), 32'd1);
    chk("out_c_load", 32'(out_c), 32'(ch));
    repeat (ack_dly) cyc();
    chk("c_load_held", 32'(c_load), 32'd1);
    c_load_done = 1'b1;
    cyc();
    chk("c_load_fall", 32'(c_load), 32'd0);
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("no_go_during_ack", 32'({conv_start, c_load}), 32'd0);
    end
    c_load_done = 1'b0;
    cyc();
    chk("conv_start_hi", 32'(conv_start), 32'd1);
    cyc();
    chk("conv_start_one", 32'(conv_start), 32'd0);
    repeat (conv_dly - 1) cyc();
    chk("out_c_stable", 32'(out_c), 32'(ch));
    conv_done = 1'b1;
    cyc();
    conv_done = 1'b0;
    if (is_last) begin
      chk("done_pulse", 32'({done, busy, c_load}), 32'b110);
      cyc();
      chk("idle_after", 32'({done, busy}), 32'b00);
    end else begin
      chk("next_load_lat", 32'(c_load), 32'd1);
    end
  endtask

  initial begin
    // Reset values
    cyc();
    cyc();
    chk("reset_outs", 32'({c_load, conv_start, busy, done, err}), 32'd0);
    chk("reset_out_c", 32'(out_c), 32'd0);
    rst = 1'b0;
    cyc();

    // Three channels, slow loader and engine
    d0 = done_cnt; c0 = cs_cnt;
    start_layer(2);
    for (int ch = 0; ch <= 2; ch++) do_channel(ch, ch == 2, 3, 0, 10);
    chk("l2_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("l2_cs_cnt", 32'(cs_cnt - c0), 32'd3);
    chk("l2_err", 32'(err), 32'd0);

    // Single channel
    r0 = rises; c0 = cs_cnt;
    start_layer(0);
    do_channel(0, 1'b1, 0, 0, 2);
    chk("l0_loads", 32'(rises - r0), 32'd1);
    chk("l0_cs_cnt", 32'(cs_cnt - c0), 32'd1);

    // Loader holds its ack after c_load drops
    r0 = rises;
    start_layer(0);
    do_channel(0, 1'b1, 1, 4, 3);
    chk("hold_loads", 32'(rises - r0), 32'd1);

    // Abort while waiting on channel 1
    d0 = done_cnt;
    start_layer(3);
    do_channel(0, 1'b0, 1, 0, 2);
    c_load_done = 1'b1;
    cyc();
    c_load_done = 1'b0;
    cyc();
    cyc();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_outs", 32'({c_load, conv_start, busy, done}), 32'd0);
    chk("abort_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    repeat (3) cyc();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    start_layer(0);
    do_channel(0, 1'b1, 0, 0, 1);

    // Spurious conv_done during LOAD
    start_layer(0);
    conv_done = 1'b1;
    cyc();
    conv_done = 1'b0;
    chk("spur_err", 32'(err), 32'd1);
    do_channel(0, 1'b1, 0, 0, 2);
    chk("spur_err_sticky", 32'(err), 32'd1);
    start_layer(0);
    chk("start_clears_err", 32'(err), 32'd0);
    do_channel(0, 1'b1, 0, 0, 1);

    // Full index range without wrap
    d0 = done_cnt; c0 = cs_cnt;
    start_layer(15);
    for (int ch = 0; ch <= 15; ch++) do_channel(ch, ch == 15, 0, 0, 1);
    chk("max_cs_cnt", 32'(cs_cnt - c0), 32'd16);
    chk("max_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("max_no_wrap", 32'(out_c), 32'd15);

    // Reset mid-LOAD with start held
    start_layer(5);
    do_channel(0, 1'b0, 0, 0, 1);
    chk("rst_pre_out_c", 32'(out_c), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    cyc();
    chk("rst_mid_outs", 32'({c_load, conv_start, busy, done, err}), 32'd0);
    chk("rst_mid_out_c", 32'(out_c), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    exp_q.delete();
    cyc();
    chk("rst_stays_idle", 32'(busy), 32'd0);

    // Loader ack while idle
    c_load_done = 1'b1;
    cyc();
    c_load_done = 1'b0;
    chk("idle_ack_err", 32'({err, busy}), 32'b10);
    start_layer(0);
    chk("idle_ack_cleared", 32'(err), 32'd0);
    do_channel(0, 1'b1, 0, 0, 1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
